// File: rtl/op_test_pkg.sv
// op_test_pkg: shared types for the operator test sequencer.
//   seq_state_t : sequencer FSM states (IDLE, ISSUE, DRAIN, DONE)
package op_test_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } seq_state_t;

endpackage : op_test_pkg

// File: rtl/op_test_sequencer_wb_delay.sv
// wb_delay_line: DEPTH-stage register chain carrying a write-back
// {enable, address} pair. Only the enable bits are reset (asynchronously);
// the address bits are plain data flops.
//   clock    : clock
//   reset    : asynchronous active-high reset (enable bits only)
//   in_en    : enable entering the chain
//   in_addr  : address entering the chain
//   out_en   : enable delayed by DEPTH cycles
//   out_addr : address delayed by DEPTH cycles
module wb_delay_line #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_en,
    output logic [WIDTH-1:0] out_addr
);

    logic             en_q   [DEPTH];
    logic [WIDTH-1:0] addr_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                en_q[i] <= 1'b0;
            end
        end else begin
            en_q[0] <= in_en;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                en_q[i] <= en_q[i-1];
            end
        end
    end

    always_ff @(posedge clock) begin
        addr_q[0] <= in_addr;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            addr_q[i] <= addr_q[i-1];
        end
    end

    assign out_en   = en_q[DEPTH-1];
    assign out_addr = addr_q[DEPTH-1];

endmodule : wb_delay_line

// File: rtl/op_test_sequencer.sv
// op_test_sequencer: issues one operand read per cycle for num_vectors
// vectors over a programmable number of passes, then drains for LATENCY
// cycles so every issued read gets its write-back, aligned with the
// operator output.
//   clock       : clock
//   reset       : asynchronous active-high reset
//   start       : start a run (accepted in IDLE or DONE)
//   abort       : stop issuing (accepted in ISSUE)
//   num_vectors : vectors per pass, 0..2^ADDR_WIDTH (latched on start)
//   loops       : passes, 0 = until abort (latched on start)
//   rd_en       : operand read strobe
//   rd_addr     : operand read address
//   wr_en       : result write strobe (rd_en delayed by LATENCY)
//   wr_addr     : result write address (rd_addr delayed by LATENCY)
//   busy        : high in ISSUE or DRAIN
//   done        : high in DONE
//   cycle_count : ISSUE+DRAIN cycles of the current/last run, saturating
//   pass_count  : completed passes, wrapping
module op_test_sequencer
    import op_test_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int LATENCY    = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int LOOP_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   num_vectors,
    input  logic [LOOP_WIDTH-1:0] loops,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [LOOP_WIDTH-1:0] pass_count
);

    if (LATENCY < 1) begin : g_bad_latency
        $fatal(1, "op_test_sequencer: LATENCY must be at least 1");
    end

    localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [ADDR_WIDTH:0]   VEC_ONE    = 1;
    localparam logic [LOOP_WIDTH-1:0] PASS_ONE   = 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;
    localparam logic [DW-1:0]         DRAIN_ONE  = 1;
    localparam logic [DW-1:0]         DRAIN_LAST = DW'(LATENCY - 1);

    seq_state_t            state,       state_n;
    logic [ADDR_WIDTH:0]   vec_cnt,     vec_n;
    logic [ADDR_WIDTH:0]   nv_q,        nv_n;
    logic [LOOP_WIDTH-1:0] loops_q,     loops_n;
    logic [LOOP_WIDTH-1:0] pass_q,      pass_n;
    logic [CNT_WIDTH-1:0]  cyc_q,       cyc_n;
    logic [DW-1:0]         drain_cnt,   drain_n;

    logic                  last_vec;
    logic                  more_passes;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vec_cnt   <= '0;
            nv_q      <= '0;
            loops_q   <= '0;
            pass_q    <= '0;
            cyc_q     <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_n;
            vec_cnt   <= vec_n;
            nv_q      <= nv_n;
            loops_q   <= loops_n;
            pass_q    <= pass_n;
            cyc_q     <= cyc_n;
            drain_cnt <= drain_n;
        end
    end

    // Pass end is decided on the full-width vector index so that a
    // 2^ADDR_WIDTH-vector pass ends at all-ones rather than on overflow.
    assign last_vec    = (vec_cnt == (nv_q - VEC_ONE));
    assign more_passes = (loops_q == '0) || ((pass_q + PASS_ONE) != loops_q);

    always_comb begin
        state_n = state;
        vec_n   = vec_cnt;
        nv_n    = nv_q;
        loops_n = loops_q;
        pass_n  = pass_q;
        cyc_n   = cyc_q;
        drain_n = drain_cnt;

        rd_en   = (state == ISSUE);
        busy    = (state == ISSUE) || (state == DRAIN);
        done    = (state == DONE);

        if (busy) begin
            cyc_n = (cyc_q == '1) ? cyc_q : (cyc_q + CNT_ONE);
        end

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    nv_n    = num_vectors;
                    loops_n = loops;
                    vec_n   = '0;
                    pass_n  = '0;
                    cyc_n   = '0;
                    drain_n = '0;
                    state_n = (num_vectors == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (last_vec) begin
                    pass_n = pass_q + PASS_ONE;
                end
                if (abort) begin
                    state_n = DRAIN;
                    drain_n = '0;
                end else if (last_vec) begin
                    if (more_passes) begin
                        vec_n = '0;
                    end else begin
                        state_n = DRAIN;
                        drain_n = '0;
                    end
                end else begin
                    vec_n = vec_cnt + VEC_ONE;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_n = DONE;
                end else begin
                    drain_n = drain_cnt + DRAIN_ONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_addr     = vec_cnt[ADDR_WIDTH-1:0];
    assign cycle_count = cyc_q;
    assign pass_count  = pass_q;

    wb_delay_line #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (LATENCY)
    ) u_wb_delay (
        .clock    (clock),
        .reset    (reset),
        .in_en    (rd_en),
        .in_addr  (rd_addr),
        .out_en   (wb_en),
        .out_addr (wb_addr)
    );

    // Address stages are unreset, so the port is masked to read 0 when idle.
    assign wr_en   = wb_en;
    assign wr_addr = wb_en ? wb_addr : '0;

endmodule : op_test_sequencer

// File: tb/tb_op_test_sequencer.sv
module tb_op_test_sequencer;

    localparam int AW = 11;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic          start_v   [2];
    logic          abort_v   [2];
    logic [AW:0]   nv_v      [2];
    logic [7:0]    loops_v   [2];
    logic          rd_en_v   [2];
    logic [AW-1:0] rd_addr_v [2];
    logic          wr_en_v   [2];
    logic [AW-1:0] wr_addr_v [2];
    logic          busy_v    [2];
    logic          done_v    [2];
    logic [31:0]   cc_v      [2];
    logic [7:0]    pc_v      [2];

    op_test_sequencer #(
        .ADDR_WIDTH (AW), .LATENCY (6), .CNT_WIDTH (32), .LOOP_WIDTH (8)
    ) dut0 (
        .clock (clock), .reset (reset), .start (start_v[0]), .abort (abort_v[0]),
        .num_vectors (nv_v[0]), .loops (loops_v[0]),
        .rd_en (rd_en_v[0]), .rd_addr (rd_addr_v[0]), .wr_en (wr_en_v[0]), .wr_addr (wr_addr_v[0]),
        .busy (busy_v[0]), .done (done_v[0]), .cycle_count (cc_v[0]), .pass_count (pc_v[0])
    );

    op_test_sequencer #(
        .ADDR_WIDTH (AW), .LATENCY (1), .CNT_WIDTH (32), .LOOP_WIDTH (8)
    ) dut1 (
        .clock (clock), .reset (reset), .start (start_v[1]), .abort (abort_v[1]),
        .num_vectors (nv_v[1]), .loops (loops_v[1]),
        .rd_en (rd_en_v[1]), .rd_addr (rd_addr_v[1]), .wr_en (wr_en_v[1]), .wr_addr (wr_addr_v[1]),
        .busy (busy_v[1]), .done (done_v[1]), .cycle_count (cc_v[1]), .pass_count (pc_v[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run is "k reads issued so far"; the read address is k mod N, a pass
    // completes whenever k hits a multiple of N, and each read produces a
    // write exactly LAT cycles later (held in a cycle-indexed schedule).
    int     m_st   [2];   // 0 idle, 1 issuing, 2 draining, 3 done
    int     m_n    [2];
    int     m_p    [2];
    int     m_k    [2];
    int     m_pass [2];
    int     m_dleft[2];
    longint m_cyc  [2];
    int     m_lat  [2] = '{6, 1};
    int     wsched [2][4096];
    int     gcyc = 0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_n[i] = 1; m_p[i] = 0; m_k[i] = 0;
            m_pass[i] = 0; m_dleft[i] = 0; m_cyc[i] = 0;
            for (int s = 0; s < 4096; s++) wsched[i][s] = -1;
        end
    endtask

    always @(negedge clock) begin
        int  slot;
        bit  exp_wr;
        if (reset) begin
            model_reset();
        end else begin
            slot = gcyc % 4096;
            for (int i = 0; i < 2; i++) begin
                exp_wr = (wsched[i][slot] >= 0);
                check($sformatf("u%0d rd_en", i), rd_en_v[i], m_st[i] == 1);
                if (m_st[i] == 1)
                    check($sformatf("u%0d rd_addr", i), rd_addr_v[i], m_k[i] % m_n[i]);
                check($sformatf("u%0d wr_en", i), wr_en_v[i], exp_wr);
                check($sformatf("u%0d wr_addr", i), wr_addr_v[i], exp_wr ? wsched[i][slot] : 0);
                check($sformatf("u%0d busy", i), busy_v[i], (m_st[i] == 1) || (m_st[i] == 2));
                check($sformatf("u%0d done", i), done_v[i], m_st[i] == 3);
                check($sformatf("u%0d cycle_count", i), cc_v[i], m_cyc[i]);
                check($sformatf("u%0d pass_count", i), pc_v[i], m_pass[i] % 256);
                wsched[i][slot] = -1;

                case (m_st[i])
                    0, 3: if (start_v[i]) begin
                        m_cyc[i] = 0; m_pass[i] = 0; m_k[i] = 0;
                        if (nv_v[i] == 0) m_st[i] = 3;
                        else begin
                            m_n[i] = int'(nv_v[i]); m_p[i] = int'(loops_v[i]); m_st[i] = 1;
                        end
                    end
                    1: begin
                        wsched[i][(gcyc + m_lat[i]) % 4096] = m_k[i] % m_n[i];
                        if (m_cyc[i] < 64'hFFFF_FFFF) m_cyc[i]++;
                        m_k[i]++;
                        if (m_k[i] % m_n[i] == 0) m_pass[i]++;
                        if (abort_v[i] || (m_p[i] != 0 && m_k[i] == m_n[i] * m_p[i])) begin
                            m_st[i] = 2; m_dleft[i] = m_lat[i];
                        end
                    end
                    2: begin
                        if (m_cyc[i] < 64'hFFFF_FFFF) m_cyc[i]++;
                        m_dleft[i]--;
                        if (m_dleft[i] == 0) m_st[i] = 3;
                    end
                    default: ;
                endcase
            end
        end
        gcyc++;
    end

    // ---------------- directed run helper ----------------
    int rd_seq[16];
    int wr_seq[16];
    int o_first_rd, o_last_rd, o_n_rd, o_last_rd_addr;
    int o_first_wr, o_last_wr, o_n_wr, o_done;

    // Cycle 0 is the cycle start is high; observation starts at cycle 1.
    task automatic run(input int i, input int nv, input int lp, input int abort_cyc,
                       input int restart_cyc, input int restart_nv, input int budget);
        @(posedge clock); #1;
        start_v[i] = 1'b1; nv_v[i] = (AW+1)'(nv); loops_v[i] = 8'(lp);
        @(posedge clock); #1;
        start_v[i] = 1'b0;
        o_first_rd = -1; o_last_rd = -1; o_n_rd = 0; o_last_rd_addr = -1;
        o_first_wr = -1; o_last_wr = -1; o_n_wr = 0; o_done = -1;
        for (int c = 1; c <= budget; c++) begin
            abort_v[i] = (c == abort_cyc);
            start_v[i] = (c == restart_cyc);
            if (c == restart_cyc) nv_v[i] = (AW+1)'(restart_nv);
            @(negedge clock);
            if (rd_en_v[i]) begin
                if (o_first_rd < 0) o_first_rd = c;
                if (o_n_rd < 16) rd_seq[o_n_rd] = int'(rd_addr_v[i]);
                o_n_rd++; o_last_rd = c; o_last_rd_addr = int'(rd_addr_v[i]);
            end
            if (wr_en_v[i]) begin
                if (o_first_wr < 0) o_first_wr = c;
                if (o_n_wr < 16) wr_seq[o_n_wr] = int'(wr_addr_v[i]);
                o_n_wr++; o_last_wr = c;
            end
            if (done_v[i]) begin
                o_done = c;
                break;
            end
            @(posedge clock); #1;
        end
        abort_v[i] = 1'b0;
        start_v[i] = 1'b0;
        check("done reached within budget", o_done >= 0, 1);
    endtask

    int exp2[6] = '{0, 1, 0, 1, 0, 1};
    int exp3[5] = '{0, 1, 2, 0, 1};
    int wr_cnt;

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; abort_v[i] = 1'b0; nv_v[i] = '0; loops_v[i] = '0;
        end
        model_reset();
        #23 reset = 1'b0;
        #1;
        check("reset rd_en", rd_en_v[0], 0);
        check("reset rd_addr", rd_addr_v[0], 0);
        check("reset wr_en", wr_en_v[0], 0);
        check("reset wr_addr", wr_addr_v[0], 0);
        check("reset busy", busy_v[0], 0);
        check("reset done", done_v[0], 0);
        check("reset cycle_count", cc_v[0], 0);
        check("reset pass_count", pc_v[0], 0);
        check("reset u1 wr_en", wr_en_v[1], 0);

        // N=4, one pass
        run(0, 4, 1, 0, 0, 0, 40);
        check("t1 first rd", o_first_rd, 1);
        check("t1 last rd", o_last_rd, 4);
        check("t1 reads", o_n_rd, 4);
        for (int j = 0; j < 4; j++) check($sformatf("t1 rd_seq[%0d]", j), rd_seq[j], j);
        check("t1 first wr", o_first_wr, 7);
        check("t1 last wr", o_last_wr, 10);
        check("t1 writes", o_n_wr, 4);
        for (int j = 0; j < 4; j++) check($sformatf("t1 wr_seq[%0d]", j), wr_seq[j], j);
        check("t1 done cycle", o_done, 11);
        check("t1 cycle_count", cc_v[0], 10);
        check("t1 pass_count", pc_v[0], 1);

        // N=2, three passes back to back
        run(0, 2, 3, 0, 0, 0, 40);
        check("t2 first rd", o_first_rd, 1);
        check("t2 last rd", o_last_rd, 6);
        check("t2 reads", o_n_rd, 6);
        for (int j = 0; j < 6; j++) check($sformatf("t2 rd_seq[%0d]", j), rd_seq[j], exp2[j]);
        check("t2 writes", o_n_wr, 6);
        check("t2 done cycle", o_done, 13);
        check("t2 pass_count", pc_v[0], 3);
        check("t2 cycle_count", cc_v[0], 12);

        // endless loops, abort in the 5th issue cycle
        run(0, 3, 0, 5, 0, 0, 40);
        check("t3 reads", o_n_rd, 5);
        for (int j = 0; j < 5; j++) check($sformatf("t3 rd_seq[%0d]", j), rd_seq[j], exp3[j]);
        check("t3 writes", o_n_wr, 5);
        for (int j = 0; j < 5; j++) check($sformatf("t3 wr_seq[%0d]", j), wr_seq[j], exp3[j]);
        check("t3 last wr", o_last_wr, 11);
        check("t3 done cycle", o_done, 12);
        check("t3 pass_count", pc_v[0], 1);
        check("t3 cycle_count", cc_v[0], 11);

        // start pulsed mid-run with a different count is ignored
        run(0, 4, 2, 0, 3, 7, 40);
        check("t4 reads", o_n_rd, 8);
        check("t4 last rd", o_last_rd, 8);
        check("t4 done cycle", o_done, 15);
        check("t4 pass_count", pc_v[0], 2);
        check("t4 cycle_count", cc_v[0], 14);

        // zero vectors: straight to DONE
        run(0, 0, 1, 0, 0, 0, 10);
        check("t5 done cycle", o_done, 1);
        check("t5 reads", o_n_rd, 0);
        check("t5 writes", o_n_wr, 0);
        check("t5 cycle_count", cc_v[0], 0);
        check("t5 pass_count", pc_v[0], 0);

        // reset in DRAIN with writes outstanding
        @(posedge clock); #1;
        start_v[0] = 1'b1; nv_v[0] = (AW+1)'(4); loops_v[0] = 8'd1;
        @(posedge clock); #1;
        start_v[0] = 1'b0;
        repeat (7) @(posedge clock);
        #2;
        check("t6 pre-reset wr_en", wr_en_v[0], 1);
        check("t6 pre-reset wr_addr", wr_addr_v[0], 1);
        check("t6 pre-reset busy", busy_v[0], 1);
        reset = 1'b1;
        #1;
        check("t6 reset wr_en", wr_en_v[0], 0);
        check("t6 reset busy", busy_v[0], 0);
        check("t6 reset done", done_v[0], 0);
        check("t6 reset rd_en", rd_en_v[0], 0);
        check("t6 reset cycle_count", cc_v[0], 0);
        check("t6 reset pass_count", pc_v[0], 0);
        @(posedge clock); #1;
        reset = 1'b0;
        wr_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (wr_en_v[0]) wr_cnt++;
        end
        check("t6 writes after reset", wr_cnt, 0);

        // full depth, LATENCY=1
        run(1, 2048, 1, 0, 0, 0, 2100);
        check("t7 first rd", o_first_rd, 1);
        check("t7 last rd", o_last_rd, 2048);
        check("t7 reads", o_n_rd, 2048);
        check("t7 last rd_addr", o_last_rd_addr, 2047);
        check("t7 last wr", o_last_wr, 2049);
        check("t7 writes", o_n_wr, 2048);
        check("t7 done cycle", o_done, 2050);
        check("t7 cycle_count", cc_v[1], 2049);
        check("t7 pass_count", pc_v[1], 1);

        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_op_test_sequencer
